// File: rtl/arith_seq_unit_if.sv
// Handshake/operand/result bundle for arith_seq_unit.
//   master: issue stage + result consumer (drives in_valid, A, B, op, out_ready)
//   slave : the arithmetic unit (drives in_ready, out_valid, result and flags)
interface arith_seq_unit_if #(
  parameter int N = 8,
  parameter int M = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     A;
  logic [N-1:0]     B;
  logic [M-2:0]     op;
  logic             out_valid;
  logic             out_ready;
  logic [2*N-1:0]   result;
  logic             carry;
  logic             zero;
  logic             div_zero;

  modport master (
    output in_valid, A, B, op, out_ready,
    input  in_ready, out_valid, result, carry, zero, div_zero
  );

  modport slave (
    input  in_valid, A, B, op, out_ready,
    output in_ready, out_valid, result, carry, zero, div_zero
  );
endinterface

// File: rtl/arith_seq_unit.sv
// arith_seq_unit: handshaked arithmetic unit, one operation in flight.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus (slave): in_valid/in_ready accept A, B, op
//                (0 add, 1 sub, 2 mul, 3 div, 4 shl, 5 shr, 6 rol, 7 ror);
//                out_valid/out_ready deliver a 2N-bit result plus
//                carry, zero and div_zero flags.
// add/sub/shift/rotate and div-by-zero complete in one cycle; mul (shift-add)
// and div (restoring) take N BUSY cycles, one step per cycle.
module arith_seq_unit #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic          clk,
  input  logic          reset,
  arith_seq_unit_if.slave bus
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DIV = 3'd3,
    OP_SHL = 3'd4, OP_SHR = 3'd5, OP_ROL = 3'd6, OP_ROR = 3'd7
  } opcode_t;

  state_t         state, state_nx;
  opcode_t        opc, op_q;
  logic [N-1:0]   a_q, b_q;
  logic [2*N-1:0] acc, acc_step;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] res_q;
  logic           carry_q, zero_q, dz_q;
  logic           accept, go_busy, last_step, load_done;

  logic [N:0]     add_sum;
  logic [2*N-1:0] fast_res, done_res;
  logic           fast_carry, fast_dz, done_carry, done_dz;

  logic [N:0]     mul_sum;
  logic [N:0]     div_rs;
  logic [N-1:0]   div_diff;
  logic           div_borrow;

  assign opc = opcode_t'(bus.op[2:0]);

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    go_busy   = 1'b0;
    load_done = 1'b0;
    last_step = (cnt == CW'(N - 1));
    unique case (state)
      IDLE: begin
        accept = bus.in_valid;
        if (accept) begin
          go_busy   = (opc == OP_MUL) || ((opc == OP_DIV) && (bus.B != '0));
          state_nx  = go_busy ? BUSY : DONE;
          load_done = !go_busy;
        end
      end
      BUSY: begin
        if (last_step) begin
          state_nx  = DONE;
          load_done = 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- single-cycle ops ----------------
  assign add_sum = {1'b0, bus.A} + {1'b0, bus.B};

  always_comb begin
    fast_res   = '0;
    fast_carry = 1'b0;
    fast_dz    = 1'b0;
    case (opc)
      OP_ADD: begin
        fast_res   = {{(N-1){1'b0}}, add_sum};
        fast_carry = add_sum[N];
      end
      OP_SUB: begin
        fast_res   = {{N{1'b0}}, bus.A - bus.B};
        fast_carry = (bus.A < bus.B);
      end
      OP_DIV: begin
        if (bus.B == '0) begin
          fast_res = {bus.A, {N{1'b1}}};
          fast_dz  = 1'b1;
        end
      end
      OP_SHL: begin
        fast_res   = {{N{1'b0}}, bus.A[N-2:0], 1'b0};
        fast_carry = bus.A[N-1];
      end
      OP_SHR: begin
        fast_res   = {{N{1'b0}}, 1'b0, bus.A[N-1:1]};
        fast_carry = bus.A[0];
      end
      OP_ROL: fast_res = {{N{1'b0}}, bus.A[N-2:0], bus.A[N-1]};
      OP_ROR: fast_res = {{N{1'b0}}, bus.A[0], bus.A[N-1:1]};
      default: ;
    endcase
  end

  // ---------------- iterative step ----------------
  // acc is shared: mul holds {partial product, remaining multiplier bits},
  // div holds {partial remainder, dividend bits -> quotient bits}.
  assign mul_sum    = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, a_q} : '0);
  assign div_rs     = acc[2*N-1:N-1];
  assign div_borrow = (div_rs < {1'b0, b_q});
  // Only used when no borrow, where the true difference fits in N bits.
  assign div_diff   = div_rs[N-1:0] - b_q;

  always_comb begin
    if (op_q == OP_MUL)
      acc_step = {mul_sum, acc[N-1:1]};
    else
      acc_step = {(div_borrow ? div_rs[N-1:0] : div_diff), acc[N-2:0], ~div_borrow};
  end

  assign done_res   = (state == BUSY) ? acc_step : fast_res;
  assign done_carry = (state == BUSY) ? 1'b0 : fast_carry;
  assign done_dz    = (state == BUSY) ? 1'b0 : fast_dz;

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      acc     <= '0;
      cnt     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      if (accept) begin
        a_q  <= bus.A;
        b_q  <= bus.B;
        op_q <= opc;
        cnt  <= '0;
        acc  <= {{N{1'b0}}, (opc == OP_DIV) ? bus.A : bus.B};
      end else if (state == BUSY) begin
        acc <= acc_step;
        cnt <= cnt + 1'b1;
      end
      if (load_done) begin
        res_q   <= done_res;
        carry_q <= done_carry;
        zero_q  <= (done_res == '0);
        dz_q    <= done_dz;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = res_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.div_zero  = dz_q;
endmodule

// File: tb/tb_arith_seq_unit.sv
// Directed bench for arith_seq_unit at N=8, M=4.
module tb_arith_seq_unit;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, MUL = 3'd2, DIV = 3'd3,
                         SHL = 3'd4, SHR = 3'd5, ROL = 3'd6, ROR = 3'd7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  arith_seq_unit_if #(.N(8), .M(4)) bus ();
  arith_seq_unit #(.N(8), .M(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string tag, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s %s: got %0h, expected %0h", tag, name, act, exp);
  endtask

  task automatic run_op(input string tag, input vec_t v);
    int waitc = 0;
    int lat = 0;
    int busy = 0;
    @(negedge clk);
    while (!bus.in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    chk(tag, "in_ready", 32'(bus.in_ready), 32'd1);
    bus.A = v.a; bus.B = v.b; bus.op = v.op; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.A = ~v.a; bus.B = ~v.b; bus.op = ~v.op;
    do begin
      @(negedge clk);
      lat++;
      if (!bus.out_valid && !bus.in_ready) busy++;
    end while (!bus.out_valid && lat < 50);
    chk(tag, "latency",  32'(lat),           32'(v.lat));
    chk(tag, "busy",     32'(busy),          32'(v.lat - 1));
    chk(tag, "result",   32'(bus.result),    32'(v.res));
    chk(tag, "carry",    32'(bus.carry),     32'(v.c));
    chk(tag, "zero",     32'(bus.zero),      32'(v.z));
    chk(tag, "div_zero", 32'(bus.div_zero),  32'(v.dz));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    vec_t v;
    int   seen;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.A = '0; bus.B = '0; bus.op = '0;

    //            op   A      B      result    c     z     dz    lat
    vecs[0]  = '{ADD, 8'hFF, 8'h01, 16'h0100, 1'b1, 1'b0, 1'b0, 1};
    vecs[1]  = '{SUB, 8'h03, 8'h05, 16'h00FE, 1'b1, 1'b0, 1'b0, 1};
    vecs[2]  = '{SUB, 8'h05, 8'h05, 16'h0000, 1'b0, 1'b1, 1'b0, 1};
    vecs[3]  = '{MUL, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 1'b0, 9};
    vecs[4]  = '{DIV, 8'h64, 8'h07, 16'h020E, 1'b0, 1'b0, 1'b0, 9};
    vecs[5]  = '{DIV, 8'h2A, 8'h00, 16'h2AFF, 1'b0, 1'b0, 1'b1, 1};
    vecs[6]  = '{SHL, 8'h81, 8'h00, 16'h0002, 1'b1, 1'b0, 1'b0, 1};
    vecs[7]  = '{SHR, 8'h81, 8'h00, 16'h0040, 1'b1, 1'b0, 1'b0, 1};
    vecs[8]  = '{ROL, 8'h81, 8'h00, 16'h0003, 1'b0, 1'b0, 1'b0, 1};
    vecs[9]  = '{ROR, 8'h81, 8'h00, 16'h00C0, 1'b0, 1'b0, 1'b0, 1};
    vecs[10] = '{MUL, 8'h00, 8'h05, 16'h0000, 1'b0, 1'b1, 1'b0, 9};
    vecs[11] = '{DIV, 8'h05, 8'h09, 16'h0500, 1'b0, 1'b0, 1'b0, 9};
    vecs[12] = '{ADD, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 1};
    vecs[13] = '{SHR, 8'h01, 8'h00, 16'h0000, 1'b1, 1'b1, 1'b0, 1};
    vecs[14] = '{DIV, 8'hFF, 8'h01, 16'h00FF, 1'b0, 1'b0, 1'b0, 9};
    vecs[15] = '{MUL, 8'h80, 8'h02, 16'h0100, 1'b0, 1'b0, 1'b0, 9};

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset", "in_ready",  32'(bus.in_ready),  32'd1);
    chk("reset", "out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset", "result",    32'(bus.result),    32'd0);
    chk("reset", "flags",     32'({bus.carry, bus.zero, bus.div_zero}), 32'd0);

    for (int unsigned i = 0; i < 16; i++)
      run_op($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: rol 0x81 held for 5 stalled cycles with in_valid pulses
    @(negedge clk);
    bus.A = 8'h81; bus.B = 8'h00; bus.op = ROL; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("stall", "out_valid", 32'(bus.out_valid), 32'd1);
    chk("stall", "result",    32'(bus.result),    32'h0003);
    for (int unsigned i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.A = 8'h01; bus.B = 8'h01; bus.op = ADD;
      @(negedge clk);
      chk($sformatf("stall%0d", i), "result",    32'(bus.result),    32'h0003);
      chk($sformatf("stall%0d", i), "out_valid", 32'(bus.out_valid), 32'd1);
      chk($sformatf("stall%0d", i), "in_ready",  32'(bus.in_ready),  32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("drain", "out_valid", 32'(bus.out_valid), 32'd0);
    chk("drain", "in_ready",  32'(bus.in_ready),  32'd1);
    @(negedge clk);
    chk("drain+1", "out_valid", 32'(bus.out_valid), 32'd0);

    // Reset during the 4th BUSY cycle of a multiply
    bus.A = 8'hFF; bus.B = 8'hFF; bus.op = MUL; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("midmul", "in_ready_busy", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midmul", "in_ready",  32'(bus.in_ready),  32'd1);
    chk("midmul", "out_valid", 32'(bus.out_valid), 32'd0);
    chk("midmul", "result",    32'(bus.result),    32'd0);
    chk("midmul", "flags",     32'({bus.carry, bus.zero, bus.div_zero}), 32'd0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("midmul", "abandoned", 32'(seen), 32'd0);
    v = '{ADD, 8'h02, 8'h03, 16'h0005, 1'b0, 1'b0, 1'b0, 1};
    run_op("post_reset_add", v);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
